// File: rtl/obstacle_collision_checker.sv
// obstacle_collision_checker: tracks the nearest first-row obstacle per lane for one frame,
// then checks the player's lane entry for a collision and reports the ground height.
module obstacle_collision_checker #(
    parameter int HIT_NEAR     = 192,
    parameter int HIT_FAR      = 256,
    parameter int LONG_EXTRA   = 64,
    parameter int JUMP_CLEAR   = 24,
    parameter int TRAIN_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_activate,
    input  logic        i_obstacle_valid,
    input  logic        i_first_row,
    input  logic [15:0] i_obstacle,
    input  logic        i_obstacle_done,
    input  logic [1:0]  i_player_lane,
    input  logic [7:0]  i_player_height,
    input  logic        i_player_duck,
    output logic        o_result_valid,
    output logic        o_collision,
    output logic [7:0]  o_ground_height,
    output logic [2:0]  o_front_type,
    output logic [10:0] o_front_depth,
    output logic [5:0]  o_obstacle_count
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EVAL, S_REPORT} state_t;
    state_t r_state, w_next;
    // Lane 3 slot is never written, so it always reads as "no obstacle".
    logic [2:0]  r_type  [4];
    logic [10:0] r_depth [4];
    logic [5:0]  r_count;
    logic [2:0]  w_beat_type, w_e_type;
    logic [1:0]  w_beat_lane;
    logic [10:0] w_beat_depth, w_e_depth, w_far;
    logic        w_in_win, w_low, w_below_roof, w_tall, w_hit, w_on_roof;
    assign w_beat_type  = i_obstacle[15:13];
    assign w_beat_lane  = i_obstacle[12:11];
    assign w_beat_depth = i_obstacle[10:0];
    assign w_e_type     = r_type[i_player_lane];
    assign w_e_depth    = r_depth[i_player_lane];
    assign w_far        = 11'(HIT_FAR) + (w_e_type[2] ? 11'(LONG_EXTRA) : 11'd0);
    assign w_in_win     = (w_e_depth >= 11'(HIT_NEAR)) && (w_e_depth <= w_far);
    assign w_low        = i_player_height < 8'(JUMP_CLEAR);
    assign w_below_roof = i_player_height < 8'(TRAIN_HEIGHT);
    assign w_tall       = (w_e_type == 3'd4) || (w_e_type == 3'd6);
    assign w_hit        = w_in_win && ((w_e_type == 3'd1) ? w_low :
                                       (w_e_type == 3'd2) ? !i_player_duck :
                                       (w_e_type == 3'd3) ? (!i_player_duck && w_low) :
                                       w_tall ? w_below_roof : 1'b0);
    assign w_on_roof    = w_in_win && ((w_e_type == 3'd5) || (w_tall && !w_below_roof));
    assign o_result_valid = (r_state == S_REPORT);
    always_comb begin
        w_next = r_state;
        if (i_activate) w_next = S_COLLECT;
        else if (r_state == S_COLLECT && i_obstacle_done) w_next = S_EVAL;
        else if (r_state == S_EVAL) w_next = S_REPORT;
        else if (r_state == S_REPORT) w_next = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_count          <= '0;
            o_collision      <= 1'b0;
            o_ground_height  <= '0;
            o_front_type     <= '0;
            o_front_depth    <= 11'h7FF;
            o_obstacle_count <= '0;
            for (int i = 0; i < 4; i++) begin
                r_type[i]  <= '0;
                r_depth[i] <= 11'h7FF;
            end
        end else begin
            r_state <= w_next;
            if (i_activate) begin
                r_count <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_type[i]  <= '0;
                    r_depth[i] <= 11'h7FF;
                end
            end else if (r_state == S_COLLECT && i_obstacle_valid) begin
                r_count <= r_count + 6'(r_count != 6'd63);
                if (i_first_row && w_beat_lane != 2'd3 && w_beat_depth < r_depth[w_beat_lane]) begin
                    r_type[w_beat_lane]  <= w_beat_type;
                    r_depth[w_beat_lane] <= w_beat_depth;
                end
            end
            if (r_state == S_EVAL && !i_activate) begin
                o_collision      <= w_hit;
                o_ground_height  <= w_on_roof ? 8'(TRAIN_HEIGHT) : 8'd0;
                o_front_type     <= w_e_type;
                o_front_depth    <= w_e_depth;
                o_obstacle_count <= r_count;
            end
        end
    end
endmodule
